// File: rtl/piso_gearbox_if.sv
// Word-in / beat-out handshake bundle for piso_gearbox.
// slave is the gearbox's view; master is the producer/consumer environment.
interface piso_gearbox_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 2
);
  logic [IN_W-1:0]  din_data;
  logic             din_valid;
  logic             din_ready;
  logic [OUT_W-1:0] dout_data;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;

  modport master (
    output din_data, din_valid, dout_ready,
    input  din_ready, dout_data, dout_valid, dout_last
  );

  modport slave (
    input  din_data, din_valid, dout_ready,
    output din_ready, dout_data, dout_valid, dout_last
  );
endinterface

// File: rtl/piso_gearbox.sv
// Parallel-in/serial-out width converter: IN_W words out as IN_W/OUT_W beats of OUT_W bits.
// One staging word behind the shift register keeps the output stream gap-free.
module piso_gearbox #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned OUT_W     = 2,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  piso_gearbox_if.slave bus,
  output logic          busy
);
  localparam int unsigned N  = IN_W / OUT_W;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  if ((IN_W % OUT_W) != 0 || N < 2) begin : g_bad_cfg
    $error("piso_gearbox: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
  end

  logic [IN_W-1:0]  sr_q, sr_d;
  logic             sr_valid_q, sr_valid_d;
  logic [IN_W-1:0]  stg_q, stg_d;
  logic             stg_valid_q, stg_valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_fire, out_fire, last_beat, sr_free;
  logic [OUT_W-1:0] beat;

  if (MSB_FIRST) begin : g_msb
    assign beat = sr_q[IN_W-1 -: OUT_W];
  end else begin : g_lsb
    assign beat = sr_q[OUT_W-1:0];
  end

  // Outputs are forced quiet while reset is asserted, not just after the edge.
  assign bus.din_ready  = rst_n & ~flush & ~stg_valid_q;
  assign bus.dout_valid = rst_n & sr_valid_q;
  assign bus.dout_last  = rst_n & sr_valid_q & last_beat;
  assign bus.dout_data  = rst_n ? beat : '0;
  assign busy           = rst_n & (sr_valid_q | stg_valid_q);

  assign last_beat = (cnt_q == LastCnt);
  assign in_fire   = bus.din_valid & bus.din_ready;
  assign out_fire  = bus.dout_valid & bus.dout_ready;
  assign sr_free   = ~sr_valid_q | (out_fire & last_beat);

  always_comb begin
    sr_d        = sr_q;
    sr_valid_d  = sr_valid_q;
    stg_d       = stg_q;
    stg_valid_d = stg_valid_q;
    cnt_d       = cnt_q;

    if (out_fire && !last_beat) begin
      sr_d  = MSB_FIRST ? (sr_q << OUT_W) : (sr_q >> OUT_W);
      cnt_d = cnt_q + CW'(1);
    end

    // in_fire implies an empty stage, so the two load sources never collide.
    if (sr_free) begin
      cnt_d = '0;
      if (stg_valid_q) begin
        sr_d        = stg_q;
        sr_valid_d  = 1'b1;
        stg_valid_d = 1'b0;
      end else if (in_fire) begin
        sr_d       = bus.din_data;
        sr_valid_d = 1'b1;
      end else begin
        sr_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      stg_d       = bus.din_data;
      stg_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      sr_q        <= '0;
      sr_valid_q  <= 1'b0;
      stg_q       <= '0;
      stg_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sr_q        <= sr_d;
      sr_valid_q  <= sr_valid_d;
      stg_q       <= stg_d;
      stg_valid_q <= stg_valid_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_piso_gearbox.sv
// Directed bench for piso_gearbox: 8->2 MSB-first, 8->2 LSB-first and 32->8 MSB-first.
module tb_piso_gearbox;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush;
  logic busy_m, busy_l, busy_w;
  int   n_tests = 0;
  int   n_fail  = 0;

  piso_gearbox_if #(.IN_W(8),  .OUT_W(2)) m_if ();
  piso_gearbox_if #(.IN_W(8),  .OUT_W(2)) l_if ();
  piso_gearbox_if #(.IN_W(32), .OUT_W(8)) w_if ();

  piso_gearbox #(.IN_W(8), .OUT_W(2), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(m_if.slave), .busy(busy_m)
  );
  piso_gearbox #(.IN_W(8), .OUT_W(2), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(l_if.slave), .busy(busy_l)
  );
  piso_gearbox #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b1)) u_wide (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(w_if.slave), .busy(busy_w)
  );

  // Hand-derived beat sequences.
  logic [1:0] exp_t1   [8]  = '{2'd3, 2'd0, 2'd3, 2'd1, 2'd0, 2'd2, 2'd1, 2'd3};
  logic [1:0] exp_full [12] = '{2'd3, 2'd0, 2'd3, 2'd1, 2'd0, 2'd2, 2'd1, 2'd3,
                                2'd2, 2'd2, 2'd1, 2'd1};
  logic [1:0] exp_lsb  [4]  = '{2'd1, 2'd3, 2'd0, 2'd3};
  logic [7:0] exp_wide [4]  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_m(input string tag, input logic [1:0] d, input logic l);
    check({tag, "_valid"}, 32'(m_if.dout_valid), 32'd1);
    check({tag, "_data"},  32'(m_if.dout_data),  32'(d));
    check({tag, "_last"},  32'(m_if.dout_last),  32'(l));
  endtask

  task automatic chk_idle_m(input string tag);
    check({tag, "_valid"}, 32'(m_if.dout_valid), 32'd0);
    check({tag, "_busy"},  32'(busy_m),          32'd0);
  endtask

  logic acc_now;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    m_if.din_data = '0; m_if.din_valid = 1'b0; m_if.dout_ready = 1'b0;
    l_if.din_data = '0; l_if.din_valid = 1'b0; l_if.dout_ready = 1'b0;
    w_if.din_data = '0; w_if.din_valid = 1'b0; w_if.dout_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(m_if.dout_valid), 32'd0);
    check("rst_last",  32'(m_if.dout_last),  32'd0);
    check("rst_data",  32'(m_if.dout_data),  32'd0);
    check("rst_busy",  32'(busy_m),          32'd0);
    check("rst_ready", 32'(m_if.din_ready),  32'd0);
    rst_n = 1'b1;
    settle();
    check("post_rst_ready", 32'(m_if.din_ready), 32'd1);

    // Back-to-back CD, 27 with free-running sink
    m_if.dout_ready = 1'b1;
    m_if.din_valid  = 1'b1;
    m_if.din_data   = 8'hCD;
    settle();
    check("t1_rdy_cd", 32'(m_if.din_ready), 32'd1);
    tick();
    m_if.din_data = 8'h27;
    settle();
    check("t1_rdy_27", 32'(m_if.din_ready), 32'd1);
    chk_m("t1_b0", exp_t1[0], 1'b0);
    tick();
    m_if.din_valid = 1'b0;
    m_if.din_data  = '0;
    settle();
    for (int i = 1; i < 8; i++) begin
      chk_m($sformatf("t1_b%0d", i), exp_t1[i], (i == 3) || (i == 7));
      check($sformatf("t1_rdy%0d", i), 32'(m_if.din_ready), (i <= 3) ? 32'd0 : 32'd1);
      tick();
    end
    chk_idle_m("t1_end");

    // Stall after the first beat
    m_if.din_valid = 1'b1;
    m_if.din_data  = 8'hCD;
    settle();
    tick();
    m_if.din_valid = 1'b0;
    settle();
    chk_m("t2_b0", 2'd3, 1'b0);
    tick();
    m_if.dout_ready = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk_m($sformatf("t2_hold%0d", i), 2'd0, 1'b0);
      tick();
    end
    m_if.dout_ready = 1'b1;
    settle();
    chk_m("t2_b1", 2'd0, 1'b0);
    tick();
    chk_m("t2_b2", 2'd3, 1'b0);
    tick();
    chk_m("t2_b3", 2'd1, 1'b1);
    tick();
    chk_idle_m("t2_end");

    // Full: SR and STG occupied, third word pending
    m_if.dout_ready = 1'b0;
    m_if.din_valid  = 1'b1;
    m_if.din_data   = 8'hCD;
    settle();
    tick();
    m_if.din_data = 8'h27;
    settle();
    check("t3_rdy_27", 32'(m_if.din_ready), 32'd1);
    tick();
    m_if.din_data = 8'hA5;
    settle();
    check("t3_rdy_full", 32'(m_if.din_ready), 32'd0);
    check("t3_busy",     32'(busy_m),         32'd1);
    chk_m("t3_hold", 2'd3, 1'b0);
    tick();
    check("t3_rdy_full2", 32'(m_if.din_ready), 32'd0);
    m_if.dout_ready = 1'b1;
    settle();
    for (int i = 0; i < 12; i++) begin
      chk_m($sformatf("t3_b%0d", i), exp_full[i], (i == 3) || (i == 7) || (i == 11));
      if (i == 3) check("t3_rdy_b3", 32'(m_if.din_ready), 32'd0);
      if (i == 4) check("t3_rdy_b4", 32'(m_if.din_ready), 32'd1);
      acc_now = m_if.din_valid & m_if.din_ready;
      tick();
      if (acc_now) m_if.din_valid = 1'b0;
      settle();
    end
    chk_idle_m("t3_end");

    // LSB-first
    l_if.dout_ready = 1'b1;
    l_if.din_valid  = 1'b1;
    l_if.din_data   = 8'hCD;
    settle();
    tick();
    l_if.din_valid = 1'b0;
    settle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_b%0d_valid", i), 32'(l_if.dout_valid), 32'd1);
      check($sformatf("t4_b%0d_data", i),  32'(l_if.dout_data),  32'(exp_lsb[i]));
      check($sformatf("t4_b%0d_last", i),  32'(l_if.dout_last),  (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    check("t4_end_valid", 32'(l_if.dout_valid), 32'd0);
    check("t4_end_busy",  32'(busy_l),          32'd0);

    // Wide 32->8
    w_if.dout_ready = 1'b1;
    w_if.din_valid  = 1'b1;
    w_if.din_data   = 32'hDEADBEEF;
    settle();
    tick();
    w_if.din_valid = 1'b0;
    settle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_b%0d_valid", i), 32'(w_if.dout_valid), 32'd1);
      check($sformatf("t5_b%0d_data", i),  32'(w_if.dout_data),  32'(exp_wide[i]));
      check($sformatf("t5_b%0d_last", i),  32'(w_if.dout_last),  (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    check("t5_end_valid", 32'(w_if.dout_valid), 32'd0);
    check("t5_end_busy",  32'(busy_w),          32'd0);

    // Reset mid-word, then flush mid-word
    for (int k = 0; k < 2; k++) begin
      m_if.dout_ready = 1'b1;
      m_if.din_valid  = 1'b1;
      m_if.din_data   = 8'hCD;
      settle();
      tick();
      m_if.din_valid = 1'b0;
      settle();
      tick();
      tick();
      chk_m($sformatf("t6_%0d_pre", k), 2'd3, 1'b0);
      if (k == 0) begin
        rst_n = 1'b0;
        settle();
        check("t6_0_during_valid", 32'(m_if.dout_valid), 32'd0);
      end else begin
        flush = 1'b1;
        settle();
        check("t6_1_during_rdy", 32'(m_if.din_ready), 32'd0);
      end
      tick();
      rst_n = 1'b1;
      flush = 1'b0;
      settle();
      chk_idle_m($sformatf("t6_%0d_after", k));
      check($sformatf("t6_%0d_rdy", k), 32'(m_if.din_ready), 32'd1);
      tick();
      tick();
      chk_idle_m($sformatf("t6_%0d_later", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
